// File: rtl/spi_dac_pkg.sv
// Shared types and constants for the SPI DAC receive model.
// Holds the FSM encoding, frame field positions and output reset values.
package spi_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam int AB_BIT   = 15;
    localparam int BUF_BIT  = 14;
    localparam int GA_BIT   = 13;
    localparam int SHDN_BIT = 12;

    localparam logic [1:0] GAIN_RST = 2'b11;
    localparam logic [1:0] SHDN_RST = 2'b00;

    // Lane positions of the three SPI wires in the synchronizer bank
    localparam int SCK_IDX  = 0;
    localparam int CS_IDX   = 1;
    localparam int MOSI_IDX = 2;
    localparam int SYNC_N   = 3;

    function automatic logic [1:0] set_lane(input logic [1:0] flags,
                                            input logic       sel,
                                            input logic       val);
        logic [1:0] res;
        res      = flags;
        res[sel] = val;
        return res;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// N-stage synchronizer for one asynchronous wire, with rise/fall detection
// taken from the last synchronized sample and one delayed copy of it.
module spi_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d_i};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign q_o    = r_sync[STAGES-1];
    assign rise_o = r_sync[STAGES-1] & ~r_prev;
    assign fall_o = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_dac_rx.sv
// Receive-side model of a 2-channel 12-bit SPI DAC, oversampling SCK/CS/MOSI.
// Define SPI_DAC_RX_LDAC_EN to buffer decoded frames until an ldac_i strobe.
module spi_dac_rx
    import spi_dac_pkg::*;
#(
    parameter int FRAME_W     = 16,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sck_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    input  logic              ldac_i,
    output logic [DATA_W-1:0] ch_a_o,
    output logic [DATA_W-1:0] ch_b_o,
    output logic [1:0]        shdn_o,
    output logic [1:0]        gain_o,
    output logic              valid_o,
    output logic              ch_o,
    output logic              err_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int CNT_W = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    logic [SYNC_N-1:0] w_raw;
    logic [SYNC_N-1:0] w_q;
    logic [SYNC_N-1:0] w_rise;
    logic [SYNC_N-1:0] w_fall;

    assign w_raw = {mosi_i, cs_i, sck_i};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_N; gi++) begin : g_sync
            spi_edge_sync #(
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .d_i    (w_raw[gi]),
                .q_o    (w_q[gi]),
                .rise_o (w_rise[gi]),
                .fall_o (w_fall[gi])
            );
        end
    endgenerate

    logic w_sck_rise;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;

    assign w_sck_rise = w_rise[SCK_IDX];
    assign w_cs_rise  = w_rise[CS_IDX];
    assign w_cs_fall  = w_fall[CS_IDX];
    assign w_mosi     = w_q[MOSI_IDX];

    state_t r_state;
    state_t w_state_next;

    logic [FRAME_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A CS fall seen during CHECK starts the next frame immediately
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_cs_fall) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_cs_rise) w_state_next = ST_CHECK;
            ST_CHECK: w_state_next = w_cs_fall ? ST_SHIFT : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // A bit coinciding with the CS rise is dropped, so it cannot be counted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_state_next == ST_SHIFT && r_state != ST_SHIFT) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == ST_SHIFT && !w_cs_rise && w_sck_rise) begin
            r_shift <= {r_shift[FRAME_W-2:0], w_mosi};
            if (r_bit_cnt != CNT_SAT) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    logic              w_good;
    logic              w_bad;
    logic              w_ab;
    logic [DATA_W-1:0] w_data;

    logic [DATA_W-1:0] w_code_a_cur;
    logic [DATA_W-1:0] w_code_b_cur;
    logic [1:0]        w_shdn_cur;
    logic [1:0]        w_gain_cur;
    logic [DATA_W-1:0] w_code_a_next;
    logic [DATA_W-1:0] w_code_b_next;
    logic [1:0]        w_shdn_next;
    logic [1:0]        w_gain_next;

    assign w_ab   = r_shift[AB_BIT];
    assign w_data = r_shift[DATA_W-1:0];

    always_comb begin
        w_good        = 1'b0;
        w_bad         = 1'b0;
        w_code_a_next = w_code_a_cur;
        w_code_b_next = w_code_b_cur;
        w_shdn_next   = w_shdn_cur;
        w_gain_next   = w_gain_cur;
        if (r_state == ST_CHECK) begin
            if (r_bit_cnt == CNT_FULL) begin
                w_good      = 1'b1;
                w_shdn_next = set_lane(w_shdn_cur, w_ab, r_shift[SHDN_BIT]);
                w_gain_next = set_lane(w_gain_cur, w_ab, r_shift[GA_BIT]);
                if (w_ab) begin
                    w_code_b_next = w_data;
                end else begin
                    w_code_a_next = w_data;
                end
            end else begin
                w_bad = 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] r_ch_a;
    logic [DATA_W-1:0] r_ch_b;
    logic [1:0]        r_shdn;
    logic [1:0]        r_gain;
    logic              r_valid;
    logic              r_err;
    logic              r_ch;
    logic [15:0]       r_frame_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_ch        <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_valid <= w_good;
            r_err   <= w_bad;
            if (w_good) begin
                r_ch        <= w_ab;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

`ifdef SPI_DAC_RX_LDAC_EN
    // Decoded fields park in input latches; ldac_i publishes them, and a
    // strobe in the CHECK cycle publishes the frame being decoded right now.
    logic [DATA_W-1:0] r_lat_a;
    logic [DATA_W-1:0] r_lat_b;
    logic [1:0]        r_lat_shdn;
    logic [1:0]        r_lat_gain;

    assign w_code_a_cur = r_lat_a;
    assign w_code_b_cur = r_lat_b;
    assign w_shdn_cur   = r_lat_shdn;
    assign w_gain_cur   = r_lat_gain;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lat_a    <= '0;
            r_lat_b    <= '0;
            r_lat_shdn <= SHDN_RST;
            r_lat_gain <= GAIN_RST;
            r_ch_a     <= '0;
            r_ch_b     <= '0;
            r_shdn     <= SHDN_RST;
            r_gain     <= GAIN_RST;
        end else begin
            r_lat_a    <= w_code_a_next;
            r_lat_b    <= w_code_b_next;
            r_lat_shdn <= w_shdn_next;
            r_lat_gain <= w_gain_next;
            if (ldac_i) begin
                r_ch_a <= w_code_a_next;
                r_ch_b <= w_code_b_next;
                r_shdn <= w_shdn_next;
                r_gain <= w_gain_next;
            end
        end
    end
`else
    assign w_code_a_cur = r_ch_a;
    assign w_code_b_cur = r_ch_b;
    assign w_shdn_cur   = r_shdn;
    assign w_gain_cur   = r_gain;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ch_a <= '0;
            r_ch_b <= '0;
            r_shdn <= SHDN_RST;
            r_gain <= GAIN_RST;
        end else begin
            r_ch_a <= w_code_a_next;
            r_ch_b <= w_code_b_next;
            r_shdn <= w_shdn_next;
            r_gain <= w_gain_next;
        end
    end
`endif

    // BUF bit and the unneeded synchronizer taps are deliberately ignored
    logic w_unused;
`ifdef SPI_DAC_RX_LDAC_EN
    assign w_unused = ^{w_q[SCK_IDX], w_fall[SCK_IDX], w_q[CS_IDX],
                        w_rise[MOSI_IDX], w_fall[MOSI_IDX], r_shift[BUF_BIT]};
`else
    assign w_unused = ^{w_q[SCK_IDX], w_fall[SCK_IDX], w_q[CS_IDX],
                        w_rise[MOSI_IDX], w_fall[MOSI_IDX], r_shift[BUF_BIT],
                        ldac_i};
`endif

    assign ch_a_o      = r_ch_a;
    assign ch_b_o      = r_ch_b;
    assign shdn_o      = r_shdn;
    assign gain_o      = r_gain;
    assign valid_o     = r_valid;
    assign ch_o        = r_ch;
    assign err_o       = r_err;
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: doc/spi_dac_rx.md
Name: spi_dac_rx

Overview:
- Receive-side model of the 2-channel 12-bit SPI DAC, placed directly downstream of the sine/2-channel SPI writer.
- Captures each MOSI frame framed by CS, decodes the channel and data fields, and holds per-channel output codes.
- Used in simulation and on-FPGA loopback to check what the writer transmitted.
- Runs entirely in the system clock domain; SCK/CS/MOSI are oversampled, not used as clocks.

Parameters:
- FRAME_W, 16, bits per SPI frame, MSB first.
- DATA_W, 12, DAC code width; occupies frame bits [DATA_W-1:0].
- SYNC_STAGES, 2, synchronizer depth on sck_i/cs_i/mosi_i (min 2).

Ports:
- clk_i  in  1  system clock (100 MHz).
- rst_ni  in  1  asynchronous reset, active-low.
- sck_i  in  1  SPI clock from writer; idle low, data sampled on rising edge.
- cs_i  in  1  SPI chip select, active-low.
- mosi_i  in  1  SPI serial data.
- ldac_i  in  1  load strobe, single-cycle pulse (used only with LDAC_EN).
- ch_a_o  out  DATA_W  channel A code.
- ch_b_o  out  DATA_W  channel B code.
- shdn_o  out  2  per-channel active flag {B,A}; 0 = shut down.
- gain_o  out  2  per-channel gain bit {B,A}; 1 = 1x, 0 = 2x.
- valid_o  out  1  one-cycle pulse on each good frame.
- ch_o  out  1  channel of last good frame; 0 = A, 1 = B.
- err_o  out  1  one-cycle pulse on each malformed frame.
- frame_cnt_o  out  16  count of good frames; wraps at 0xFFFF to 0.

Behaviour:
- Reset values: ch_a_o = ch_b_o = 0, shdn_o = 2'b00, gain_o = 2'b11, valid_o = err_o = 0, ch_o = 0, frame_cnt_o = 0. Synchronizers and shift register also clear.
- Inputs pass through SYNC_STAGES flops. SCK rising and CS falling/rising edges are detected from the last two synchronized samples.
- Required SCK period is at least 4 clk_i cycles; the writer's clk_div output meets this.
- Frame bit map: [15] A/B select, [14] BUF (ignored), [13] GA, [12] SHDN, [11:0] data.
- FSM states:
  - IDLE: on CS fall, clear shift register and bit counter, go to SHIFT.
  - SHIFT: on each SCK rise, shift MOSI into the LSB and increment the bit counter, which saturates at FRAME_W+1. On CS rise, go to CHECK.
  - CHECK: lasts one cycle. If bit count == FRAME_W, the frame is good: update the selected channel's code, shdn, and gain; set ch_o; pulse valid_o; increment frame_cnt_o. Otherwise pulse err_o and leave all other outputs unchanged. Return to IDLE.
- Latency: valid_o is asserted SYNC_STAGES+2 clk_i cycles after the raw CS rising edge.
- SCK rise while CS is high is ignored.
- SCK rise and CS rise on the same synchronized sample: the bit is not counted.
- A CS fall detected in CHECK is honoured on the next cycle, so back-to-back frames are not lost.
- Reset asserted mid-frame aborts the frame silently, with no err_o pulse.
- More than FRAME_W bits, fewer than FRAME_W bits, or zero bits in a frame all give err_o.

Optional Feature:
- Macro: SPI_DAC_RX_LDAC_EN.
- With the macro defined:
  - Decoded fields go to an input latch per channel; ch_a_o/ch_b_o/shdn_o/gain_o copy from the latches only on ldac_i = 1.
  - ldac_i and CHECK in the same cycle: the new frame is written to the latch and also passes through to the outputs in that cycle.
  - valid_o still pulses at CHECK.
- Without the macro: outputs update at CHECK; ldac_i is ignored.

Decomposition:
- Package spi_dac_pkg holds:
  - State encoding: IDLE, SHIFT, CHECK.
  - Frame bit-position constants: AB_BIT = 15, BUF_BIT = 14, GA_BIT = 13, SHDN_BIT = 12.
  - Reset constants for gain and shdn.
- One sub-module, spi_edge_sync: N-stage synchronizer plus rise/fall detect, instantiated for sck, cs, and mosi.

Test Plan:
- Frame 0x3ABC (A, 1x, active), SCK period 20 clk -> ch_a_o = 0xABC, shdn_o[0] = 1, gain_o[0] = 1, ch_o = 0, valid_o one pulse, frame_cnt_o = 1.
- Frame 0xB123 then 0x1FFF, back-to-back with a 1-SCK CS gap:
  - ch_b_o = 0x123, then ch_a_o = 0xFFF.
  - gain_o[0] = 0 after 0x1FFF.
  - Two valid_o pulses, frame_cnt_o = 2.
- CS raised after 15 bits, then a 17-bit frame -> err_o pulses twice; ch_a_o, ch_b_o, and frame_cnt_o unchanged.
- rst_ni low for 3 cycles at bit 8 of 0x3555, then a full frame 0x3AAA -> all outputs at reset values after reset; no err_o; then ch_a_o = 0xAAA.
- Drive the sine writer for a full sine period -> ch_a_o/ch_b_o sequence equals rom_sin contents; err_o never asserts.
- SPI_DAC_RX_LDAC_EN defined: frame 0x3123, outputs stay 0; ldac_i pulse -> ch_a_o = 0x123 on the next cycle.
